// File: rtl/ddr_serializer.sv
// rtl/ddr_serializer.sv - multi-lane double-buffered DDR output serializer
//
// Accepts one WORD-bit word per lane through in_valid/in_ready and shifts each
// lane out two bits per clock through a per-lane DDR pad cell.
//   clock, reset : single clock, synchronous active-high reset
//   in_data      : lane i = in_data[i*WORD +: WORD]
//   in_valid     : in_data valid
//   in_ready     : word accepted on a rising edge when in_valid && in_ready
//   out_pins     : DDR pad outputs, one per lane
//   out_twice    : registered beat per lane, [2i] first half-cycle, [2i+1] second
//   word_start   : high while out_twice carries beat 0 of a word
//   underflow    : high while out_twice carries beat 0 of an idle word inserted
//                  after the first accepted word
module ddr_serializer #(
    parameter int              LANES     = 4,
    parameter int              WORD      = 10,
    parameter int              MSB_FIRST = 0,
    parameter logic [WORD-1:0] IDLE      = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LANES*WORD-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_pins,
    output logic [2*LANES-1:0]     out_twice,
    output logic                   word_start,
    output logic                   underflow
);

    localparam int BEATS = WORD / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam int NB = LANES * WORD;

    // Masks clearing the two bits of each lane that would otherwise receive
    // bits from the neighbouring lane during a 2-bit shift of the flat vector.
    function automatic logic [NB-1:0] edge_mask(input bit top);
        logic [NB-1:0] m;
        m = '1;
        for (int l = 0; l < LANES; l++) begin
            if (top) begin
                m[l*WORD + WORD - 1] = 1'b0;
                m[l*WORD + WORD - 2] = 1'b0;
            end else begin
                m[l*WORD]     = 1'b0;
                m[l*WORD + 1] = 1'b0;
            end
        end
        return m;
    endfunction

    localparam logic [NB-1:0] MASK_TOP = edge_mask(1'b1);
    localparam logic [NB-1:0] MASK_BOT = edge_mask(1'b0);

    logic [NB-1:0]      hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [NB-1:0]      shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic               idle_ins_q, idle_ins_d;
    logic [2*LANES-1:0] out_twice_q, out_twice_d;
    logic               word_start_q, word_start_d;
    logic               underflow_q, underflow_d;
    logic               load;
    logic               accept;

    always_comb begin
        load     = (cnt_q == LAST);
        in_ready = !hold_full_q || load;
        accept   = in_valid && in_ready;

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        idle_ins_d  = idle_ins_q;

        if (load) begin
            shift_d     = hold_full_q ? hold_q : {LANES{IDLE}};
            idle_ins_d  = !hold_full_q && armed_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end else begin
            if (MSB_FIRST != 0) begin
                shift_d = (shift_q << 2) & MASK_BOT;
            end else begin
                shift_d = (shift_q >> 2) & MASK_TOP;
            end
            cnt_d = cnt_q + CW'(1);
        end

        // Every accepted word goes through hold; there is no bypass to shift.
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
            armed_d     = 1'b1;
        end

        out_twice_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (MSB_FIRST != 0) begin
                out_twice_d[2*l]     = shift_q[l*WORD + WORD - 1];
                out_twice_d[2*l + 1] = shift_q[l*WORD + WORD - 2];
            end else begin
                out_twice_d[2*l]     = shift_q[l*WORD];
                out_twice_d[2*l + 1] = shift_q[l*WORD + 1];
            end
        end
        word_start_d = (cnt_q == '0);
        underflow_d  = (cnt_q == '0) && idle_ins_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= {LANES{IDLE}};
            cnt_q        <= LAST;
            armed_q      <= 1'b0;
            idle_ins_q   <= 1'b0;
            out_twice_q  <= '0;
            word_start_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            idle_ins_q   <= idle_ins_d;
            out_twice_q  <= out_twice_d;
            word_start_q <= word_start_d;
            underflow_q  <= underflow_d;
        end
    end

    assign out_twice  = out_twice_q;
    assign word_start = word_start_q;
    assign underflow  = underflow_q;

    for (genvar i = 0; i < LANES; i++) begin : g_pad
`ifdef MOJO
        ODDR2 #(
            .DDR_ALIGNMENT("C0"),
            .INIT(1'b0),
            .SRTYPE("SYNC")
        ) u_oddr (
            .Q (out_pins[i]),
            .C0(clock),
            .C1(~clock),
            .CE(1'b1),
            .D0(out_twice_q[2*i]),
            .D1(out_twice_q[2*i + 1]),
            .R (1'b0),
            .S (1'b0)
        );
`elsif ECP5
        ODDRX1F u_oddr (
            .SCLK(clock),
            .RST (1'b0),
            .D0  (out_twice_q[2*i]),
            .D1  (out_twice_q[2*i + 1]),
            .Q   (out_pins[i])
        );
`else
        // The second half-beat is staged on the rising edge so both halves
        // of one out_twice value leave the pad within the same clock period.
        logic rise_q;
        logic fall_stage_q;
        logic fall_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                rise_q       <= 1'b0;
                fall_stage_q <= 1'b0;
            end else begin
                rise_q       <= out_twice_q[2*i];
                fall_stage_q <= out_twice_q[2*i + 1];
            end
        end

        always_ff @(negedge clock) begin
            fall_q <= fall_stage_q;
        end

        assign out_pins[i] = clock ? rise_q : fall_q;
`endif
    end

endmodule

// File: tb/tb_ddr_serializer.sv
// tb/tb_ddr_serializer.sv - self-checking bench for ddr_serializer
module tb_ddr_serializer;

    localparam int LANES = 2;
    localparam int WORD  = 4;
    localparam int BEATS = WORD / 2;
    localparam int NB    = LANES * WORD;
    localparam logic [WORD-1:0] IDLE_W = '0;

    typedef struct packed {
        logic [2*LANES-1:0] tw_l;
        logic [2*LANES-1:0] tw_m;
        logic               ws;
        logic               uf;
        logic               data;
        logic [7:0]         beat;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NB-1:0]      in_data = '0;
    logic               in_valid = 1'b0;
    logic               rdy0, rdy1;
    logic [LANES-1:0]   pins0, pins1;
    logic [2*LANES-1:0] tw0, tw1;
    logic               ws0, ws1, uf0, uf1;

    ddr_serializer #(.LANES(LANES), .WORD(WORD), .MSB_FIRST(0), .IDLE(IDLE_W)) dut_lsb (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .out_pins(pins0), .out_twice(tw0),
        .word_start(ws0), .underflow(uf0)
    );

    ddr_serializer #(.LANES(LANES), .WORD(WORD), .MSB_FIRST(1), .IDLE(IDLE_W)) dut_msb (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .out_pins(pins1), .out_twice(tw1),
        .word_start(ws1), .underflow(uf1)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: a word-level schedule of expected beats.
    exp_t             exp_q[$];
    exp_t             cur;
    int               t;
    bit               pend_v;
    logic [NB-1:0]    pend;
    bit               armed;
    bit               last_acc;
    bit               pins_ok = 1'b0;
    logic [LANES-1:0] pin_hi_l, pin_lo_l, pin_hi_m, pin_lo_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2*LANES-1:0] beat_of(input logic [NB-1:0] w, input int k, input bit msb);
        logic [2*LANES-1:0] r;
        logic [WORD-1:0]    lw;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            lw = WORD'(w >> (i * WORD));
            if (msb) begin
                r[2*i]     = lw[WORD - 1 - 2*k];
                r[2*i + 1] = lw[WORD - 2 - 2*k];
            end else begin
                r[2*i]     = lw[2*k];
                r[2*i + 1] = lw[2*k + 1];
            end
        end
        return r;
    endfunction

    function automatic logic [LANES-1:0] half_of(input logic [2*LANES-1:0] tw, input int sel);
        logic [LANES-1:0] r;
        for (int i = 0; i < LANES; i++) r[i] = tw[2*i + sel];
        return r;
    endfunction

    task automatic model_reset();
        exp_t e;
        e = '0;
        t = 0;
        pend_v = 1'b0;
        armed = 1'b0;
        exp_q.delete();
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit v, input logic [NB-1:0] d, input bit rst);
        bit            load, rdy, acc;
        exp_t          e;
        logic [NB-1:0] w;
        @(negedge clock);
        in_valid = v;
        in_data  = d;
        reset    = rst;
        #1;
        if (pins_ok) begin
            chk("pins_lo_lsb", 32'(pins0), 32'(pin_lo_l));
            chk("pins_lo_msb", 32'(pins1), 32'(pin_lo_m));
        end
        load = (t % BEATS) == 0;
        rdy  = !pend_v || load;
        acc  = v && rdy;
        chk("in_ready_lsb", 32'(rdy0), 32'(rdy));
        chk("in_ready_msb", 32'(rdy1), 32'(rdy));
        @(posedge clock);
        if (rst) begin
            pin_hi_l = '0; pin_lo_l = '0; pin_hi_m = '0; pin_lo_m = '0;
            model_reset();
            cur = '0;
            last_acc = 1'b0;
        end else begin
            pin_hi_l = half_of(cur.tw_l, 0);
            pin_lo_l = half_of(cur.tw_l, 1);
            pin_hi_m = half_of(cur.tw_m, 0);
            pin_lo_m = half_of(cur.tw_m, 1);
            if (load) begin
                w = pend_v ? pend : {LANES{IDLE_W}};
                for (int k = 0; k < BEATS; k++) begin
                    e.tw_l = beat_of(w, k, 1'b0);
                    e.tw_m = beat_of(w, k, 1'b1);
                    e.ws   = (k == 0);
                    e.uf   = (k == 0) && !pend_v && armed;
                    e.data = pend_v;
                    e.beat = 8'(k);
                    exp_q.push_back(e);
                end
                pend_v = 1'b0;
            end
            if (acc) begin
                pend   = d;
                pend_v = 1'b1;
                armed  = 1'b1;
            end
            last_acc = acc;
            cur = exp_q.pop_front();
            t++;
        end
        pins_ok = 1'b1;
        #1;
        chk("out_twice_lsb", 32'(tw0), 32'(cur.tw_l));
        chk("out_twice_msb", 32'(tw1), 32'(cur.tw_m));
        chk("word_start_lsb", 32'(ws0), 32'(cur.ws));
        chk("word_start_msb", 32'(ws1), 32'(cur.ws));
        chk("underflow_lsb", 32'(uf0), 32'(cur.uf));
        chk("underflow_msb", 32'(uf1), 32'(cur.uf));
        chk("pins_hi_lsb", 32'(pins0), 32'(pin_hi_l));
        chk("pins_hi_msb", 32'(pins1), 32'(pin_hi_m));
    endtask

    initial begin
        int            n;
        int            guard;
        logic [NB-1:0] d;

        model_reset();
        cur = '0;

        // Reset, then idle running unarmed.
        repeat (3) cycle(1'b0, '0, 1'b1);
        chk("reset_out_twice", 32'(tw0), 32'h0);
        chk("reset_in_ready", 32'(rdy0), 32'h1);
        repeat (6) cycle(1'b0, NB'($urandom), 1'b0);

        // Single word accepted one edge before a load edge.
        while ((t % BEATS) != BEATS - 1) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 8'h6B, 1'b0);
        cycle(1'b0, NB'($urandom), 1'b0);
        cycle(1'b0, NB'($urandom), 1'b0);
        chk("single_beat0_lsb", 32'(tw0), 32'hB);
        chk("single_beat0_msb", 32'(tw1), 32'h9);
        chk("single_word_start", 32'(ws0), 32'h1);
        cycle(1'b0, NB'($urandom), 1'b0);
        chk("single_beat1_lsb", 32'(tw0), 32'h6);
        chk("single_beat1_msb", 32'(tw1), 32'h7);
        repeat (4) cycle(1'b0, NB'($urandom), 1'b0);

        // Stream of three words with in_valid held high, then starvation.
        n = 0;
        guard = 0;
        d = NB'($urandom);
        while (n < 3 && guard < 40) begin
            cycle(1'b1, d, 1'b0);
            if (last_acc) begin
                n++;
                d = NB'($urandom);
            end
            guard++;
        end
        chk("stream_accepted", 32'(n), 32'd3);
        repeat (8) cycle(1'b0, NB'($urandom), 1'b0);

        // Reset while beat 1 of a data word is on out_twice and hold is full.
        guard = 0;
        while (!(cur.data && cur.beat == 8'd1 && pend_v) && guard < 40) begin
            cycle(1'b1, NB'($urandom), 1'b0);
            guard++;
        end
        chk("midword_reached", 32'(guard < 40), 32'h1);
        cycle(1'b1, NB'($urandom), 1'b1);
        chk("midword_reset_twice", 32'(tw0), 32'h0);
        repeat (8) cycle(1'b0, NB'($urandom), 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, NB'($urandom), $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
